// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 INCR-burst memory subordinate with independent read/write FSMs; optional AXI_MEM_RESP_ERR_EN flags out-of-range beats with SLVERR
module axi_mem_responder #(
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int MEM_WORDS = 4096
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                aw_valid_i,
    output logic                aw_ready_o,
    input  logic [31:0]         aw_addr_i,
    input  logic [ID_W-1:0]     aw_id_i,
    input  logic [7:0]          aw_len_i,
    input  logic                w_valid_i,
    output logic                w_ready_o,
    input  logic [DATA_W-1:0]   w_data_i,
    input  logic [DATA_W/8-1:0] w_strb_i,
    input  logic                w_last_i,
    output logic                b_valid_o,
    input  logic                b_ready_i,
    output logic [ID_W-1:0]     b_id_o,
    output logic [1:0]          b_resp_o,
    input  logic                ar_valid_i,
    output logic                ar_ready_o,
    input  logic [31:0]         ar_addr_i,
    input  logic [ID_W-1:0]     ar_id_i,
    input  logic [7:0]          ar_len_i,
    output logic                r_valid_o,
    input  logic                r_ready_i,
    output logic [DATA_W-1:0]   r_data_o,
    output logic [ID_W-1:0]     r_id_o,
    output logic [1:0]          r_resp_o,
    output logic                r_last_o
);
    localparam int SW  = DATA_W / 8;
    localparam int OFF = $clog2(SW);
    localparam int AW  = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    w_state_t        w_state_q, w_state_d;
    logic [ID_W-1:0] w_id_q, w_id_d;
    logic [31:0]     w_addr_q, w_addr_d;
    logic [7:0]      w_len_q, w_len_d;
    logic [7:0]      w_cnt_q, w_cnt_d;
    logic            w_err_q, w_err_d;
    logic            mem_we;

    r_state_t        r_state_q, r_state_d;
    logic [ID_W-1:0] r_id_q, r_id_d;
    logic [31:0]     r_addr_q, r_addr_d;
    logic [7:0]      r_len_q, r_len_d;
    logic [7:0]      r_cnt_q, r_cnt_d;

    logic [AW-1:0]   w_idx, r_idx;
    logic            w_oor, r_oor;

    assign w_idx = w_addr_q[OFF +: AW];
    assign r_idx = r_addr_q[OFF +: AW];

`ifdef AXI_MEM_RESP_ERR_EN
    localparam logic [32:0] LIMIT = 33'(MEM_WORDS) * 33'(SW);
    assign w_oor = {1'b0, w_addr_q} >= LIMIT;
    assign r_oor = (r_state_q == R_DATA) && ({1'b0, r_addr_q} >= LIMIT);
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    // Write channel: accept AW, absorb beats with last-flag checking, then hold B until taken
    always_comb begin
        w_state_d  = w_state_q;
        w_id_d     = w_id_q;
        w_addr_d   = w_addr_q;
        w_len_d    = w_len_q;
        w_cnt_d    = w_cnt_q;
        w_err_d    = w_err_q;
        mem_we     = 1'b0;
        aw_ready_o = w_state_q == W_IDLE;
        w_ready_o  = w_state_q == W_DATA;
        b_valid_o  = w_state_q == W_RESP;
        case (w_state_q)
            W_IDLE: if (aw_valid_i) begin
                w_id_d    = aw_id_i;
                w_addr_d  = aw_addr_i;
                w_len_d   = aw_len_i;
                w_cnt_d   = 8'd0;
                w_err_d   = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (w_valid_i) begin
                mem_we    = !rst_i && !w_oor;
                w_err_d   = w_err_q | w_oor | (w_last_i != (w_cnt_q == w_len_q));
                w_addr_d  = w_addr_q + 32'(SW);
                w_cnt_d   = w_cnt_q + 8'd1;
                w_state_d = (w_cnt_q == w_len_q) ? W_RESP : W_DATA;
            end
            W_RESP: w_state_d = b_ready_i ? W_IDLE : W_RESP;
            default: w_state_d = W_IDLE;
        endcase
    end

    assign b_id_o   = w_id_q;
    assign b_resp_o = w_err_q ? 2'b10 : 2'b00;

    // Write-side registers; reset abandons any burst in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    // Byte-enabled storage write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we)
            for (int b = 0; b < SW; b++)
                if (w_strb_i[b]) mem[w_idx][b*8 +: 8] <= w_data_i[b*8 +: 8];
    end

    // Read channel: accept AR, then stream one beat per accepted R handshake
    always_comb begin
        r_state_d  = r_state_q;
        r_id_d     = r_id_q;
        r_addr_d   = r_addr_q;
        r_len_d    = r_len_q;
        r_cnt_d    = r_cnt_q;
        ar_ready_o = r_state_q == R_IDLE;
        r_valid_o  = r_state_q == R_DATA;
        r_last_o   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
        case (r_state_q)
            R_IDLE: if (ar_valid_i) begin
                r_id_d    = ar_id_i;
                r_addr_d  = ar_addr_i;
                r_len_d   = ar_len_i;
                r_cnt_d   = 8'd0;
                r_state_d = R_DATA;
            end
            R_DATA: if (r_ready_i) begin
                r_addr_d  = r_addr_q + 32'(SW);
                r_cnt_d   = r_cnt_q + 8'd1;
                r_state_d = (r_cnt_q == r_len_q) ? R_IDLE : R_DATA;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign r_id_o   = r_id_q;
    assign r_resp_o = r_oor ? 2'b10 : 2'b00;
    assign r_data_o = r_oor ? '0 : mem[r_idx];

    // Read-side registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed scoreboard bench for axi_mem_responder (honours AXI_MEM_RESP_ERR_EN)
module tb_axi_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aw_valid = 0, aw_ready;
    logic [31:0] aw_addr = 0;
    logic [3:0]  aw_id = 0;
    logic [7:0]  aw_len = 0;
    logic        w_valid = 0, w_ready, w_last = 0;
    logic [63:0] w_data = 0;
    logic [7:0]  w_strb = 0;
    logic        b_valid, b_ready = 0;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid = 0, ar_ready;
    logic [31:0] ar_addr = 0;
    logic [3:0]  ar_id = 0;
    logic [7:0]  ar_len = 0;
    logic        r_valid, r_ready = 0, r_last;
    logic [63:0] r_data;
    logic [3:0]  r_id;
    logic [1:0]  r_resp;

    typedef struct {logic [63:0] data; logic last; logic [1:0] resp;} rexp_t;
    rexp_t       rq[$];
    logic [1:0]  bq[$];
    logic [63:0] model [4096];
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  id_ctr = 4'd1;

    axi_mem_responder dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr), .aw_id_i(aw_id), .aw_len_i(aw_len),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr), .ar_id_i(ar_id), .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data),
        .r_id_o(r_id), .r_resp_o(r_resp), .r_last_o(r_last)
    );

    always #5 clk = ~clk;

    function automatic logic oor(input logic [31:0] a);
`ifdef AXI_MEM_RESP_ERR_EN
        return a >= 32'h8000;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [11:0] idx(input logic [31:0] a);
        return a[14:3];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [63:0] base,
                            input logic [7:0] strb, input int last_at, input int bdelay);
        logic [31:0] a;
        logic        err;
        logic [3:0]  id;
        int          n;
        a = addr; err = 0; id = id_ctr; id_ctr++;
        aw_valid = 1; aw_addr = addr; aw_id = id; aw_len = len;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (aw_ready) break;
            cyc();
        end
        if (n == 50) chk("aw_timeout", 0, 1);
        cyc();
        aw_valid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            w_valid = 1; w_data = base + 64'(i); w_strb = strb; w_last = (i == last_at);
            if ((i == int'(len)) != (i == last_at) || oor(a)) err = 1;
            for (n = 0; n < 50; n++) begin
                @(negedge clk);
                if (w_ready) break;
                cyc();
            end
            if (n == 50) chk("w_timeout", 0, 1);
            if (!oor(a))
                for (int b = 0; b < 8; b++)
                    if (strb[b]) model[idx(a)][b*8 +: 8] = w_data[b*8 +: 8];
            a = a + 32'd8;
            cyc();
        end
        w_valid = 0; w_last = 0;
        bq.push_back(err ? 2'b10 : 2'b00);
        for (int k = 0; k < bdelay; k++) begin
            @(negedge clk);
            chk("b_hold_valid", 64'(b_valid), 1);
            chk("b_hold_resp", 64'(b_resp), 64'(bq[0]));
            chk("b_hold_id", 64'(b_id), 64'(id));
            cyc();
        end
        b_ready = 1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (b_valid) break;
            cyc();
        end
        if (n == 50) chk("b_timeout", 0, 1);
        chk("b_resp", 64'(b_resp), 64'(bq.pop_front()));
        chk("b_id", 64'(b_id), 64'(id));
        cyc();
        b_ready = 0;
        @(negedge clk);
        chk("aw_ready_after_b", 64'(aw_ready), 1);
        chk("b_valid_after_b", 64'(b_valid), 0);
        cyc();
    endtask

    task automatic push_reads(input logic [31:0] addr, input logic [7:0] len);
        logic [31:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 32'(i * 8);
            rq.push_back('{oor(a) ? 64'd0 : model[idx(a)], i == int'(len), oor(a) ? 2'b10 : 2'b00});
        end
    endtask

    task automatic start_read(input logic [31:0] addr, input logic [7:0] len, output logic [3:0] id);
        int n;
        id = id_ctr; id_ctr++;
        push_reads(addr, len);
        ar_valid = 1; ar_addr = addr; ar_id = id; ar_len = len;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ar_ready) break;
            cyc();
        end
        if (n == 50) chk("ar_timeout", 0, 1);
        cyc();
        ar_valid = 0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input bit toggle);
        logic [3:0] id;
        bit         ph;
        int         guard;
        start_read(addr, len, id);
        ph = 0; guard = 0;
        while (rq.size() > 0 && guard < 2000) begin
            r_ready = toggle ? ph : 1'b1;
            ph = !ph;
            @(negedge clk);
            chk("r_valid", 64'(r_valid), 1);
            chk("ar_ready_busy", 64'(ar_ready), 0);
            chk("r_data", r_data, rq[0].data);
            chk("r_last", 64'(r_last), 64'(rq[0].last));
            chk("r_resp", 64'(r_resp), 64'(rq[0].resp));
            chk("r_id", 64'(r_id), 64'(id));
            if (r_ready) void'(rq.pop_front());
            cyc();
            guard++;
        end
        chk("r_drain", 64'(rq.size()), 0);
        r_ready = 0;
        @(negedge clk);
        chk("r_valid_done", 64'(r_valid), 0);
        chk("ar_ready_done", 64'(ar_ready), 1);
        cyc();
    endtask

    initial begin
        logic [3:0]  rid;
        logic [63:0] old;
        rst = 1;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_aw_ready", 64'(aw_ready), 1);
        chk("rst_ar_ready", 64'(ar_ready), 1);
        chk("rst_w_ready", 64'(w_ready), 0);
        chk("rst_b_valid", 64'(b_valid), 0);
        chk("rst_r_valid", 64'(r_valid), 0);
        chk("rst_r_last", 64'(r_last), 0);
        chk("rst_ids_resps", {54'd0, b_id, r_id, b_resp, r_resp}, 0);
        cyc();
        rst = 0;

        do_write(32'h0, 8'd255, 64'h100, 8'hFF, 255, 0);
        do_read(32'h0, 8'd255, 0);

        do_write(32'h1000, 8'd3, 64'hA0, 8'hFF, 3, 0);
        chk("model_a0", model[idx(32'h1000)], 64'hA0);
        do_read(32'h1000, 8'd3, 0);

        do_write(32'h20, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
        do_write(32'h20, 8'd0, 64'h0, 8'h0F, 0, 0);
        chk("model_strb", model[idx(32'h20)], 64'hFFFF_FFFF_0000_0000);
        do_read(32'h20, 8'd0, 0);

        do_read(32'h0, 8'd7, 1);

        do_write(32'h40, 8'd1, 64'hB0, 8'hFF, 0, 5);
        do_read(32'h40, 8'd1, 0);

        old = model[idx(32'h300)];
        aw_valid = 1; aw_addr = 32'h300; aw_len = 0; aw_id = 4'h9;
        ar_valid = 1; ar_addr = 32'h300; ar_len = 0; ar_id = 4'hA;
        @(negedge clk);
        chk("dual_aw_ready", 64'(aw_ready), 1);
        chk("dual_ar_ready", 64'(ar_ready), 1);
        cyc();
        aw_valid = 0; ar_valid = 0;
        w_valid = 1; w_data = 64'hDEAD_BEEF_0000_0001; w_strb = 8'hFF; w_last = 1; r_ready = 1;
        @(negedge clk);
        chk("dual_w_ready", 64'(w_ready), 1);
        chk("dual_r_valid", 64'(r_valid), 1);
        chk("dual_pre_write_data", r_data, old);
        chk("dual_r_last", 64'(r_last), 1);
        cyc();
        model[idx(32'h300)] = 64'hDEAD_BEEF_0000_0001;
        w_valid = 0; w_last = 0; r_ready = 0; b_ready = 1;
        @(negedge clk);
        chk("dual_b_valid", 64'(b_valid), 1);
        chk("dual_b_resp", 64'(b_resp), 0);
        cyc();
        b_ready = 0;
        do_read(32'h300, 8'd0, 0);

        start_read(32'h0, 8'd7, rid);
        r_ready = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("pre_rst_r_data", r_data, rq[0].data);
            void'(rq.pop_front());
            cyc();
        end
        rst = 1;
        cyc();
        @(negedge clk);
        chk("mid_rst_r_valid", 64'(r_valid), 0);
        chk("mid_rst_ar_ready", 64'(ar_ready), 1);
        chk("mid_rst_r_last", 64'(r_last), 0);
        chk("mid_rst_r_id", 64'(r_id), 0);
        cyc();
        rst = 0; r_ready = 0;
        rq.delete();
        do_read(32'h0, 8'd3, 0);

        do_write(32'h7FF8, 8'd0, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 0);
        do_read(32'hFFFF_FFF8, 8'd1, 0);
        do_read(32'h8000, 8'd0, 0);
`ifndef AXI_MEM_RESP_ERR_EN
        chk("alias_8000", model[idx(32'h8000)], model[idx(32'h0)]);
`endif
        do_write(32'h8000, 8'd0, 64'h5555, 8'hFF, 0, 0);
        do_read(32'h0, 8'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
